// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction-fetch stage sitting behind the pc block. Runs a
//            single-outstanding req/ack read on the instruction-memory bus,
//            writes the fetched word and its address into the IF/ID register,
//            parks a word in a one-entry hold buffer while decode is stalled,
//            and drops in-flight fetches when a branch is taken.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-low reset
//   pc_i           in   current PC from the pc block
//   branchEnable_i in   branch taken this cycle (flush)
//   stall_i        in   decode stall, IF/ID must hold
//   pcStall_o      out  tells pc to hold its value
//   memReq_o       out  instruction-memory read request
//   memAddr_o      out  read address, stable while memReq_o=1
//   memAck_i       in   memory acknowledge, data valid same cycle
//   memData_i      in   read data
//   id_pc_o        out  IF/ID address of id_inst_o
//   id_inst_o      out  IF/ID instruction word
//   id_valid_o     out  IF/ID holds a real instruction
// ============================================================================
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              branchEnable_i,
    input  logic              stall_i,
    output logic              pcStall_o,
    output logic              memReq_o,
    output logic [ADDR_W-1:0] memAddr_o,
    input  logic              memAck_i,
    input  logic [DATA_W-1:0] memData_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [DATA_W-1:0] hold_inst_q, hold_inst_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [DATA_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;

    // Candidate instruction for IF/ID this cycle (from the bus or the hold buffer)
    logic              w_new_valid;
    logic [ADDR_W-1:0] w_new_pc;
    logic [DATA_W-1:0] w_new_inst;
    logic              w_ack_ok;

    // An ack only delivers an instruction if the fetch was not already
    // condemned by an earlier branch and no branch is flushing right now.
    assign w_ack_ok = (state_q == S_WAIT) && memAck_i && !discard_q && !branchEnable_i;

    assign memReq_o   = (state_q == S_WAIT);
    assign memAddr_o  = addr_q;
    // pc advances exactly once per delivered instruction, even when the word
    // is diverted into the hold buffer.
    assign pcStall_o  = !w_ack_ok;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        discard_d   = discard_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = id_valid_q;
        w_new_valid = 1'b0;
        w_new_pc    = '0;
        w_new_inst  = NOP_INST;

        case (state_q)
            S_ISSUE: begin
                // On a branch pc loads the target at this edge; capture it next cycle.
                if (!branchEnable_i) begin
                    addr_d    = pc_i;
                    discard_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memAck_i) begin
                    if (w_ack_ok && stall_i) begin
                        hold_pc_d   = addr_q;
                        hold_inst_d = memData_i;
                        state_d     = S_HOLD;
                    end else begin
                        state_d = S_ISSUE;
                        if (w_ack_ok) begin
                            w_new_valid = 1'b1;
                            w_new_pc    = addr_q;
                            w_new_inst  = memData_i;
                        end
                    end
                end else if (branchEnable_i) begin
                    // The bus transaction cannot be cancelled; let it finish and drop it.
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (branchEnable_i) begin
                    state_d = S_ISSUE;
                end else if (!stall_i) begin
                    state_d     = S_ISSUE;
                    w_new_valid = 1'b1;
                    w_new_pc    = hold_pc_q;
                    w_new_inst  = hold_inst_q;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase

        // IF/ID update: flush beats stall, stall beats load, otherwise bubble.
        if (branchEnable_i) begin
            id_valid_d  = 1'b0;
            id_inst_d   = NOP_INST;
            hold_pc_d   = '0;
            hold_inst_d = '0;
        end else if (stall_i) begin
            id_valid_d = id_valid_q;
        end else if (w_new_valid) begin
            id_valid_d = 1'b1;
            id_pc_d    = w_new_pc;
            id_inst_d  = w_new_inst;
        end else begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_ISSUE;
            addr_q      <= '0;
            discard_q   <= 1'b0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
            id_pc_q     <= '0;
            id_inst_q   <= NOP_INST;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage placed directly downstream of the pc block. It consumes pc_o and runs a single-outstanding request/acknowledge read on the instruction-memory bus. It registers the fetched word with its address into the IF/ID pipeline register for decode, and tells pc when to hold. It also handles decode stalls (through a one-entry hold buffer) and branch flushes.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
NOP_INST, 32'h0000_0000, value driven on id_inst_o when the stage holds no valid instruction

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  reset; synchronous, active-low (rst=0 at a posedge resets)
pc_i  in  ADDR_W  current PC, from pc.pc_o
branchEnable_i  in  1  branch taken this cycle; the same signal drives pc; acts as a flush here
stall_i  in  1  decode/hazard stall; IF/ID must hold its contents
pcStall_o  out  1  to pc: hold the current PC; pc gives branchEnable_i priority over this input
memReq_o  out  1  instruction-memory read request
memAddr_o  out  ADDR_W  read address; stable while memReq_o=1
memAck_i  in  1  memory acknowledge; memData_i is valid in the same cycle
memData_i  in  DATA_W  read data
id_pc_o  out  ADDR_W  IF/ID: address of id_inst_o
id_inst_o  out  DATA_W  IF/ID: instruction word
id_valid_o  out  1  IF/ID: contents are a real instruction

Behaviour:
- States:
  - ISSUE: latch address.
  - WAIT: request outstanding.
  - HOLD: fetched word parked because IF/ID is stalled.
- Internal registers:
  - addr_r: drives memAddr_o.
  - discard_r: set when the outstanding fetch must be dropped.
  - hold_pc_r / hold_inst_r: the one-entry hold buffer.
- Reset (rst=0 at posedge), from any state, including mid-WAIT:
  - state=ISSUE, addr_r=0, discard_r=0, hold buffer cleared.
  - id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0.
  - Combinational consequences: memReq_o=0, pcStall_o=1.
- memReq_o = (state==WAIT).
- ISSUE:
  - pcStall_o=1.
  - If branchEnable_i=1: stay in ISSUE. pc loads the target at this edge and the target is captured next cycle.
  - Else: addr_r<=pc_i, discard_r<=0, go to WAIT.
- WAIT:
  - addr_r is unchanged.
  - Accepted ack = memAck_i && !discard_r && !branchEnable_i.
  - pcStall_o = !(accepted ack), so pc advances exactly once per delivered instruction.
  - Accepted ack with stall_i=0: IF/ID<= {addr_r, memData_i, valid=1}; go to ISSUE.
  - Accepted ack with stall_i=1: hold buffer<= {addr_r, memData_i}; go to HOLD; IF/ID unchanged.
  - memAck_i=1 with discard_r=1 or branchEnable_i=1: data dropped; go to ISSUE.
  - branchEnable_i=1 without memAck_i: discard_r<=1; stay in WAIT (the request completes on the bus and is then dropped).
- HOLD:
  - memReq_o=0, pcStall_o=1.
  - When stall_i=0: hold buffer -> IF/ID with valid=1; go to ISSUE.
- IF/ID update priority, highest first:
  1. Reset.
  2. branchEnable_i=1: id_valid_o<=0, id_inst_o<=NOP_INST, hold buffer cleared, HOLD->ISSUE. Flush beats stall_i.
  3. stall_i=1: all IF/ID outputs hold.
  4. New instruction from WAIT or HOLD: load it.
  5. Otherwise: bubble (id_valid_o<=0, id_inst_o<=NOP_INST, id_pc_o holds).
- Latency and throughput:
  - id_valid_o rises on the edge ending the accepted-ack cycle.
  - With zero-wait memory (ack in the first WAIT cycle): 1 instruction per 2 cycles.
  - With N wait cycles: 1 instruction per N+2 cycles.
- No instruction is lost or duplicated across stall_i transitions.
- No flushed-path instruction ever reaches IF/ID with id_valid_o=1.

Test Plan:
1. Reset: rst=0 for 3 cycles with memAck_i=1 and stall_i=1 -> memReq_o=0, pcStall_o=1, id_valid_o=0, id_inst_o=0x00000000, id_pc_o=0 throughout.
2. Zero-wait stream: memAck_i tied to 1, memData_i=addr|0xA0000000, pc resets to 0 and steps by 4 -> memAddr_o sequence 0x0,0x4,0x8; id_valid_o pulses every 2nd cycle with (id_pc_o,id_inst_o)=(0x0,0xA0000000),(0x4,0xA0000004),(0x8,0xA0000008).
3. Wait states: ack 3 cycles after the request at address 0x10 -> memReq_o=1 for 3 cycles, memAddr_o constant at 0x10, pcStall_o=1 until the ack cycle then 0 for exactly 1 cycle, single id_valid_o pulse.
4. Stall/hold: stall_i=1 while IF/ID holds 0x4; ack for 0x8 arrives -> IF/ID stays 0x4 and memReq_o drops. Release stall_i -> next edge shows id_pc_o=0x8, then fetch of 0xC; no duplicate and no loss.
5. Branch mid-wait: branchEnable_i pulse (target 0x100) in WAIT cycle 1, ack in cycle 3 with data 0xDEADBEEF -> 0xDEADBEEF never valid in IF/ID; next memAddr_o=0x100.
6. Branch with stall_i=1 and HOLD occupied -> id_valid_o=0 next cycle, held word discarded, next request at the target. Then rst=0 mid-WAIT -> memReq_o=0 and id_valid_o=0 the following cycle.
